// File: rtl/imp_moment_buffer.sv
// imp_moment_buffer: collects an N-sample vector of signed 8-bit activations,
// computes the mean (Q8.1) and the mean of squares, then replays the buffered
// samples in arrival order with those statistics attached.
// Optional build macro IMP_MOMENT_ROUND_EN: round-to-nearest (ties up) on both
// divisions instead of truncation. Interface and latency are identical.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accept samples, accumulate sum and sum of squares
// CALC    | one cycle, register mean and mean of squares
// REPLAY  | N cycles, stream buffered samples with statistics attached

module imp_moment_buffer #(
    parameter int N = 8
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_valid,
    input  logic signed [7:0] i_x,
    output logic              o_ready,
    output logic              o_valid,
    output logic signed [7:0] o_x,
    output logic signed [8:0] o_Ex,
    output logic [15:0]       o_Ex2,
    output logic              o_last
);

    localparam int LOG2N = $clog2(N);
    localparam int SW    = 8 + LOG2N;
    localparam int QW    = 15 + LOG2N;
    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

`ifdef IMP_MOMENT_ROUND_EN
    localparam int EX_RND_SH = (LOG2N >= 2) ? (LOG2N - 2) : 0;
    localparam int EX_RND    = (LOG2N >= 2) ? (1 << EX_RND_SH) : 0;
    localparam int EX2_RND   = 1 << (LOG2N - 1);
`else
    localparam int EX_RND    = 0;
    localparam int EX2_RND   = 0;
`endif

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_CALC    = 2'd1,
        S_REPLAY  = 2'd2
    } state_t;

    state_t                  state;
    logic [LOG2N-1:0]        cnt;
    logic signed [SW-1:0]    sum;
    logic [QW-1:0]           sq;
    logic signed [7:0]       sample_buf [N];

    logic signed [15:0]      x_sq;
    logic signed [SW-1:0]    ex_full;
    logic [QW-1:0]           ex2_full;

    // Square of the incoming sample and the scaled statistics from the accumulators
    always_comb begin
        x_sq     = i_x * i_x;
        ex_full  = (sum + SW'(EX_RND)) >>> (LOG2N - 1);
        ex2_full = (sq + QW'(EX2_RND)) >> LOG2N;
    end

    // Sequencer: collect, compute statistics, replay the buffer
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= S_COLLECT;
            cnt     <= '0;
            sum     <= '0;
            sq      <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_x     <= '0;
            o_Ex    <= '0;
            o_Ex2   <= '0;
            o_last  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                sample_buf[i] <= '0;
            end
        end else begin
            case (state)
                S_COLLECT: begin
                    if (i_valid) begin
                        sample_buf[cnt] <= i_x;
                        sum             <= sum + SW'(i_x);
                        sq              <= sq + QW'($unsigned(x_sq));
                        cnt             <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state   <= S_CALC;
                            o_ready <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    o_Ex    <= 9'(ex_full);
                    o_Ex2   <= 16'(ex2_full);
                    // The first sample goes out on this edge so o_valid rises the cycle after CALC
                    o_valid <= 1'b1;
                    o_x     <= sample_buf[0];
                    o_last  <= 1'b0;
                    cnt     <= LOG2N'(1);
                    state   <= S_REPLAY;
                end
                S_REPLAY: begin
                    if (o_last) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        o_ready <= 1'b1;
                        cnt     <= '0;
                        sum     <= '0;
                        sq      <= '0;
                        state   <= S_COLLECT;
                    end else begin
                        o_x    <= sample_buf[cnt];
                        o_last <= (cnt == CNT_LAST);
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= S_COLLECT;
                    cnt     <= '0;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imp_moment_buffer.sv
// Directed testbench for imp_moment_buffer (N=8).

module tb_imp_moment_buffer;

    logic              i_clk;
    logic              i_rstn;
    logic              i_valid;
    logic signed [7:0] i_x;
    logic              o_ready;
    logic              o_valid;
    logic signed [7:0] o_x;
    logic signed [8:0] o_Ex;
    logic [15:0]       o_Ex2;
    logic              o_last;

    int checks   = 0;
    int failures = 0;
    logic signed [7:0] vec [8];

    imp_moment_buffer #(.N(8)) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_valid (i_valid),
        .i_x     (i_x),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_x     (o_x),
        .o_Ex    (o_Ex),
        .o_Ex2   (o_Ex2),
        .o_last  (o_last)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 8; i++) vec[i] = 8'(v);
    endtask

    // Drive vec back-to-back; returns in the CALC cycle
    task automatic send_vector();
        for (int i = 0; i < 8; i++) begin
            chk("ready_before_send", 32'(o_ready), 32'd1);
            i_valid = 1'b1;
            i_x     = vec[i];
            tick();
        end
        i_valid = 1'b0;
        i_x     = 8'sd0;
    endtask

    // Called in the CALC cycle; returns in the cycle o_ready is high again
    task automatic check_replay(input string tag, input int exp_ex, input int exp_ex2);
        chk({tag, "_calc_ready"}, 32'(o_ready), 32'd0);
        chk({tag, "_calc_valid"}, 32'(o_valid), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_valid"}, 32'(o_valid), 32'd1);
            chk({tag, "_ready_low"}, 32'(o_ready), 32'd0);
            chk({tag, "_x"}, 32'(o_x), 32'(vec[i]));
            chk({tag, "_ex"}, 32'(o_Ex), 32'(exp_ex));
            chk({tag, "_ex2"}, 32'(o_Ex2), 32'(exp_ex2));
            chk({tag, "_last"}, 32'(o_last), (i == 7) ? 32'd1 : 32'd0);
            tick();
        end
        chk({tag, "_ready_back"}, 32'(o_ready), 32'd1);
        chk({tag, "_valid_end"}, 32'(o_valid), 32'd0);
        chk({tag, "_ex_hold"}, 32'(o_Ex), 32'(exp_ex));
        chk({tag, "_ex2_hold"}, 32'(o_Ex2), 32'(exp_ex2));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_x"}, 32'(o_x), 32'd0);
        chk({tag, "_ex"}, 32'(o_Ex), 32'd0);
        chk({tag, "_ex2"}, 32'(o_Ex2), 32'd0);
        chk({tag, "_last"}, 32'(o_last), 32'd0);
    endtask

    initial begin
        int accepted;
        int budget;
        int exp_ex2_ramp;

`ifdef IMP_MOMENT_ROUND_EN
        exp_ex2_ramp = 18;
`else
        exp_ex2_ramp = 17;
`endif
        i_rstn  = 1'b0;
        i_valid = 1'b0;
        i_x     = 8'sd0;
        #12;
        chk_zero_outputs("reset");
        @(negedge i_clk);
        i_rstn = 1'b1;
        tick();
        chk_zero_outputs("post_reset");

        // Constant 4
        set_all(4);
        send_vector();
        check_replay("const4", 8, 16);

        // Ramp 0..7: sum 28, sq 140
        for (int i = 0; i < 8; i++) vec[i] = 8'(i);
        send_vector();
        check_replay("ramp", 7, exp_ex2_ramp);

        // Random gaps, then i_valid held high with junk through CALC/REPLAY
        vec[0] = 8'sd10;  vec[1] = -8'sd20; vec[2] = 8'sd30;  vec[3] = -8'sd40;
        vec[4] = 8'sd50;  vec[5] = -8'sd60; vec[6] = 8'sd70;  vec[7] = -8'sd80;
        accepted = 0;
        budget   = 0;
        while (accepted < 8 && budget < 200) begin
            i_valid = 1'($urandom_range(0, 1));
            i_x     = i_valid ? vec[accepted] : 8'sd99;
            tick();
            if (i_valid) accepted++;
            budget++;
        end
        chk("gap_budget", 32'(accepted), 32'd8);
        i_valid = 1'b1;
        i_x     = 8'sd100;
        check_replay("gaps", -10, 2550);
        i_valid = 1'b0;
        i_x     = 8'sd0;

        // Dropped samples must not leak into the next vector
        set_all(-1);
        send_vector();
        check_replay("neg1", -2, 1);

        set_all(-128);
        send_vector();
        check_replay("neg128", -256, 16384);

        // Reset after a partial vector
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_x     = 8'sd9;
            tick();
        end
        i_valid = 1'b0;
        #2;
        i_rstn = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        @(negedge i_clk);
        i_rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_after_reset_valid", 32'(o_valid), 32'd0);
        end
        set_all(2);
        send_vector();
        check_replay("two", 4, 4);

        // Two vectors back-to-back
        set_all(3);
        send_vector();
        check_replay("b2b_3", 6, 9);
        set_all(-5);
        send_vector();
        check_replay("b2b_m5", -10, 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
